// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - L1 cache to AXI4 INCR burst bridge
// Independent read and write FSMs; 16-byte write buffer drives wr_rdy.
module cache_axi_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_request,
  input  logic [2:0]              read_type,
  input  logic [31:0]             read_addr,
  output logic                    read_ready,
  output logic                    return_valid,
  output logic                    return_last,
  output logic [31:0]             return_data,
  input  logic                    write_request,
  input  logic [2:0]              write_type,
  input  logic [31:0]             write_addr,
  input  logic [3:0]              write_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [31:0]             rdata,
  input  logic                    rlast,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0]              r_state;
  logic [31:0]             r_addr;
  logic [2:0]              r_type;
  logic [1:0]              w_state;
  logic [31:0]             w_addr;
  logic [2:0]              w_type;
  logic [3:0]              w_strb;
  logic [32*LINE_WORDS-1:0] w_buf;
  logic [CW-1:0]           w_cnt;
  logic                    aw_done;
  logic                    w_data_done;

  logic r_line, w_line, hazard, w_last_beat, aw_fin, w_fin;

  assign r_line = (r_type == TYPE_LINE);
  assign w_line = (w_type == TYPE_LINE);

  // Hold off reads that hit the line still sitting in the write buffer.
  assign hazard     = (w_state != W_IDLE) && (read_addr[31:4] == w_addr[31:4]);
  assign read_ready = (r_state == R_IDLE) && !hazard;

  assign arvalid = (r_state == R_AR);
  assign araddr  = r_addr;
  assign arlen   = r_line ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize  = r_line ? 3'd2 : {1'b0, r_type[1:0]};
  assign arburst = 2'b01;

  assign rready       = (r_state == R_DATA);
  assign return_valid = rready & rvalid;
  assign return_last  = rready & rvalid & rlast;
  assign return_data  = rdata;

  assign wr_rdy  = (w_state == W_IDLE);
  assign awvalid = (w_state == W_REQ) && !aw_done;
  assign awaddr  = w_addr;
  assign awlen   = w_line ? 8'(LINE_WORDS - 1) : 8'd0;
  assign awsize  = w_line ? 3'd2 : {1'b0, w_type[1:0]};
  assign awburst = 2'b01;

  assign w_last_beat = w_line ? (w_cnt == CW'(LINE_WORDS - 1)) : 1'b1;
  assign wvalid      = (w_state == W_REQ) && !w_data_done;
  assign wdata       = w_buf[{w_cnt, 5'b0} +: 32];
  assign wstrb       = w_line ? 4'hF : w_strb;
  assign wlast       = w_last_beat;
  assign bready      = (w_state == W_RESP);

  // Either channel may finish first or both in the same cycle.
  assign aw_fin = aw_done | (awvalid & awready);
  assign w_fin  = w_data_done | (wvalid & wready & w_last_beat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_type  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (read_request && read_ready) begin
          r_addr  <= read_addr;
          r_type  <= read_type;
          r_state <= R_AR;
        end
        R_AR:   if (arready) r_state <= R_DATA;
        R_DATA: if (rvalid && rlast) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_type      <= '0;
      w_strb      <= '0;
      w_buf       <= '0;
      w_cnt       <= '0;
      aw_done     <= 1'b0;
      w_data_done <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (write_request) begin
          w_addr      <= write_addr;
          w_type      <= write_type;
          w_strb      <= write_wstrb;
          w_buf       <= wr_data;
          w_cnt       <= '0;
          aw_done     <= 1'b0;
          w_data_done <= 1'b0;
          w_state     <= W_REQ;
        end
        W_REQ: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready) begin
            if (w_last_beat) w_data_done <= 1'b1;
            else             w_cnt <= w_cnt + 1'b1;
          end
          if (aw_fin && w_fin) w_state <= W_RESP;
        end
        W_RESP: if (bvalid) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
